pagerank_sweep_ctrl: RTL and testbench

- Control FSM for one PageRank run in the accelerator datapath.
- Accepts a job (node count N, iteration count K) over a val/rdy handshake.
- Drives the datapath's source/destination select indices, accumulator clear/enable, rank-write enable and double-buffer bank select.
- Signals completion over a second val/rdy handshake. Contains no arithmetic datapath itself.

---
 rtl/pagerank_sweep_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pagerank_sweep_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pagerank_sweep_ctrl.sv
// Sequencing FSM for one PageRank run: rank init, then per-iteration
// clear/accumulate/write sweeps over all destination nodes, with double-buffered ranks.
module pagerank_sweep_ctrl #(
  parameter int unsigned NODE_BITS = 3,
  parameter int unsigned ITER_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [NODE_BITS:0]   in_num_nodes,
  input  logic [ITER_BITS-1:0] in_num_iters,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [NODE_BITS-1:0] src_idx,
  output logic [NODE_BITS-1:0] dst_idx,
  output logic                 src_sel,
  output logic                 acc_clear,
  output logic                 acc_en,
  output logic                 rank_wr_en,
  output logic                 bank_sel,
  output logic [ITER_BITS-1:0] iter_count
);

  localparam int unsigned NW = NODE_BITS + 1;
  localparam logic [NODE_BITS:0] MAX_NODES = NW'(2 ** NODE_BITS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CLEAR = 3'd2,
    ACCUM = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [NODE_BITS:0]   n_q, n_d;
  logic [ITER_BITS-1:0] k_q, k_d;
  logic [NODE_BITS-1:0] src_q, src_d;
  logic [NODE_BITS-1:0] dst_q, dst_d;
  logic                 bank_q, bank_d;
  logic [ITER_BITS-1:0] iter_q, iter_d;
  logic                 in_rdy_q, in_rdy_d;
  logic                 out_val_q, out_val_d;
  logic                 src_sel_q, src_sel_d;
  logic                 acc_clear_q, acc_clear_d;
  logic                 acc_en_q, acc_en_d;
  logic                 rank_wr_en_q, rank_wr_en_d;

  logic [NODE_BITS:0]   n_sat;
  logic [NODE_BITS-1:0] last_idx;
  logic [ITER_BITS-1:0] iter_inc;

  assign n_sat    = (in_num_nodes > MAX_NODES) ? MAX_NODES : in_num_nodes;
  assign last_idx = NODE_BITS'(n_q - NW'(1));
  assign iter_inc = iter_q + ITER_BITS'(1);

  // Next-state, counters and registered-strobe decode of the next state
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    src_d   = src_q;
    dst_d   = dst_q;
    bank_d  = bank_q;
    iter_d  = iter_q;

    case (state_q)
      IDLE: begin
        if (in_val && in_rdy_q) begin
          n_d     = n_sat;
          k_d     = in_num_iters;
          dst_d   = '0;
          iter_d  = '0;
          bank_d  = 1'b0;
          state_d = (n_sat == '0) ? DONE : INIT;
        end
      end
      INIT: begin
        if (dst_q == last_idx) begin
          dst_d   = '0;
          state_d = (k_q == '0) ? DONE : CLEAR;
        end else begin
          dst_d = dst_q + NODE_BITS'(1);
        end
      end
      CLEAR: begin
        src_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (src_q == last_idx) begin
          state_d = WRITE;
        end else begin
          src_d = src_q + NODE_BITS'(1);
        end
      end
      WRITE: begin
        if (dst_q != last_idx) begin
          dst_d   = dst_q + NODE_BITS'(1);
          state_d = CLEAR;
        end else begin
          // Iteration boundary: swap rank buffers
          dst_d   = '0;
          bank_d  = ~bank_q;
          iter_d  = iter_inc;
          state_d = (iter_inc == k_q) ? DONE : CLEAR;
        end
      end
      DONE: begin
        if (out_val_q && out_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_rdy_d     = (state_d == IDLE);
    out_val_d    = (state_d == DONE);
    rank_wr_en_d = (state_d == INIT) || (state_d == WRITE);
    src_sel_d    = (state_d == WRITE);
    acc_clear_d  = (state_d == CLEAR);
    acc_en_d     = (state_d == ACCUM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      k_q          <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      bank_q       <= 1'b0;
      iter_q       <= '0;
      in_rdy_q     <= 1'b1;
      out_val_q    <= 1'b0;
      src_sel_q    <= 1'b0;
      acc_clear_q  <= 1'b0;
      acc_en_q     <= 1'b0;
      rank_wr_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      k_q          <= k_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      bank_q       <= bank_d;
      iter_q       <= iter_d;
      in_rdy_q     <= in_rdy_d;
      out_val_q    <= out_val_d;
      src_sel_q    <= src_sel_d;
      acc_clear_q  <= acc_clear_d;
      acc_en_q     <= acc_en_d;
      rank_wr_en_q <= rank_wr_en_d;
    end
  end

  assign in_rdy     = in_rdy_q;
  assign out_val    = out_val_q;
  assign src_idx    = src_q;
  assign dst_idx    = dst_q;
  assign src_sel    = src_sel_q;
  assign acc_clear  = acc_clear_q;
  assign acc_en     = acc_en_q;
  assign rank_wr_en = rank_wr_en_q;
  assign bank_sel   = bank_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_pagerank_sweep_ctrl.sv
// Directed bench for pagerank_sweep_ctrl: job table with hand-computed latency and
// strobe counts, plus cycle traces for the N=2 job and a mid-job reset.
module tb_pagerank_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [3:0] in_num_nodes;
  logic [7:0] in_num_iters;
  logic       out_val;
  logic       out_rdy;
  logic [2:0] src_idx;
  logic [2:0] dst_idx;
  logic       src_sel;
  logic       acc_clear;
  logic       acc_en;
  logic       rank_wr_en;
  logic       bank_sel;
  logic [7:0] iter_count;

  int n_cmp = 0;
  int n_err = 0;

  pagerank_sweep_ctrl #(.NODE_BITS(3), .ITER_BITS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_val       (in_val),
    .in_rdy       (in_rdy),
    .in_num_nodes (in_num_nodes),
    .in_num_iters (in_num_iters),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .src_idx      (src_idx),
    .dst_idx      (dst_idx),
    .src_sel      (src_sel),
    .acc_clear    (acc_clear),
    .acc_en       (acc_en),
    .rank_wr_en   (rank_wr_en),
    .bank_sel     (bank_sel),
    .iter_count   (iter_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n; int k; int dly; int scr;
    int lat; int wr; int en; int clr;
    int bank; int iter; int chk_bi;
  } job_t;

  // strobes packed as {rank_wr_en, src_sel, acc_clear, acc_en}; which: 0 none, 1 dst, 2 src
  typedef struct {
    logic [3:0] code; int which; int idx;
  } step_t;

  job_t  jobs[8];
  step_t trace[10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {rank_wr_en, src_sel, acc_clear, acc_en};
  endfunction

  task automatic run_job(input string tag, input job_t j);
    int cyc = 1, wr = 0, en = 0, clr = 0, viol = 0, hold_viol = 0;
    int eff, bank_at = -1, iter_at = -1;
    bit seen = 0;
    eff = (j.n > 8) ? 8 : j.n;
    in_num_nodes = 4'(j.n);
    in_num_iters = 8'(j.k);
    out_rdy      = (j.dly == 0);
    in_val       = 1'b1;
    tick();
    in_val = 1'b0;
    while (!seen && cyc <= 2000) begin
      if (out_val) begin
        seen    = 1;
        bank_at = int'(bank_sel);
        iter_at = int'(iter_count);
        if (strobes() != 4'b0 || in_rdy) viol++;
      end else begin
        wr  += int'(rank_wr_en);
        en  += int'(acc_en);
        clr += int'(acc_clear);
        if (int'(rank_wr_en) + int'(acc_en) + int'(acc_clear) > 1 || in_rdy) viol++;
        if (rank_wr_en && int'(dst_idx) >= eff) viol++;
        if (acc_en && int'(src_idx) >= eff) viol++;
        if (j.scr != 0) begin
          in_num_nodes = 4'($urandom);
          in_num_iters = 8'($urandom);
        end
        tick();
        cyc++;
      end
    end
    check({tag, " latency"}, seen ? cyc : -1, j.lat);
    check({tag, " rank_wr count"}, wr, j.wr);
    check({tag, " acc_en count"}, en, j.en);
    check({tag, " acc_clear count"}, clr, j.clr);
    check({tag, " strobe/index violations"}, viol, 0);
    if (!seen) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      return;
    end
    for (int d = 0; d < j.dly; d++) begin
      tick();
      if (!out_val) hold_viol++;
    end
    if (j.dly > 0) check({tag, " out_val hold"}, hold_viol, 0);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check({tag, " in_rdy after done"}, int'(in_rdy), 1);
    check({tag, " out_val after done"}, int'(out_val), 0);
    if (j.chk_bi != 0) begin
      check({tag, " bank_sel"}, bank_at, j.bank);
      check({tag, " iter_count"}, iter_at, j.iter);
      check({tag, " bank_sel in idle"}, int'(bank_sel), j.bank);
      check({tag, " iter_count in idle"}, int'(iter_count), j.iter);
    end
  endtask

  initial begin
    int viol;
    bit found;
    //          n   k dly scr lat  wr   en  clr bank iter chk
    jobs[0] = '{2,  1, 0, 0,  11,  4,   4,  2,  1,  1,  1};
    jobs[1] = '{8,  3, 5, 0, 249, 32, 192, 24,  1,  3,  1};
    jobs[2] = '{0,  5, 0, 0,   1,  0,   0,  0,  0,  0,  0};
    jobs[3] = '{4,  0, 0, 0,   5,  4,   0,  0,  0,  0,  1};
    jobs[4] = '{15, 1, 0, 0,  89, 16,  64,  8,  1,  1,  1};
    jobs[5] = '{1,  4, 2, 0,  14,  5,   4,  4,  0,  4,  1};
    jobs[6] = '{3,  2, 0, 0,  34,  9,  18,  6,  0,  2,  1};
    jobs[7] = '{5,  2, 1, 1,  76, 15,  50, 10,  0,  2,  1};

    trace[0] = '{4'b1000, 1, 0};
    trace[1] = '{4'b1000, 1, 1};
    trace[2] = '{4'b0010, 0, 0};
    trace[3] = '{4'b0001, 2, 0};
    trace[4] = '{4'b0001, 2, 1};
    trace[5] = '{4'b1100, 1, 0};
    trace[6] = '{4'b0010, 0, 0};
    trace[7] = '{4'b0001, 2, 0};
    trace[8] = '{4'b0001, 2, 1};
    trace[9] = '{4'b1100, 1, 1};

    reset = 1'b1; in_val = 1'b0; out_rdy = 1'b0;
    in_num_nodes = '0; in_num_iters = '0;
    tick();
    tick();
    check("reset in_rdy", int'(in_rdy), 1);
    check("reset out_val", int'(out_val), 0);
    check("reset bank_sel", int'(bank_sel), 0);
    check("reset iter_count", int'(iter_count), 0);
    check("reset strobes", int'(strobes()), 0);
    reset = 1'b0;

    viol = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!in_rdy || out_val || strobes() != 4'b0 || bank_sel) viol++;
    end
    check("idle hold", viol, 0);

    // Cycle-accurate trace of N=2, K=1
    in_num_nodes = 4'd2; in_num_iters = 8'd1; in_val = 1'b1; out_rdy = 1'b0;
    tick();
    in_val = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("trace c%0d strobes", c + 1), int'(strobes()), int'(trace[c].code));
      if (trace[c].which == 1) check($sformatf("trace c%0d dst", c + 1), int'(dst_idx), trace[c].idx);
      if (trace[c].which == 2) check($sformatf("trace c%0d src", c + 1), int'(src_idx), trace[c].idx);
      check($sformatf("trace c%0d out_val", c + 1), int'(out_val), 0);
      tick();
    end
    check("trace c11 out_val", int'(out_val), 1);
    check("trace bank_sel", int'(bank_sel), 1);
    check("trace iter_count", int'(iter_count), 1);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check("trace in_rdy after done", int'(in_rdy), 1);

    for (int i = 0; i < 8; i++) run_job($sformatf("job%0d", i), jobs[i]);

    // Reset in the middle of an accumulate sweep
    in_num_nodes = 4'd4; in_num_iters = 8'd2; in_val = 1'b1; out_rdy = 1'b1;
    tick();
    in_val = 1'b0;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (acc_en) found = 1;
      else tick();
    end
    check("abort reached accum", int'(found), 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort in_rdy", int'(in_rdy), 1);
    check("abort strobes", int'(strobes()), 0);
    check("abort out_val", int'(out_val), 0);
    viol = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_val || !in_rdy || strobes() != 4'b0) viol++;
    end
    check("abort quiet", viol, 0);
    run_job("post-abort", jobs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
